vga_timing_gen: RTL

//  Parametrised VGA raster timing generator with built-in test-pattern source.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_pattern.sv | 48 ++++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, pattern mode encodings and a sync-level helper.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam logic [1:0] MODE_BLACK = 2'd0;
    localparam logic [1:0] MODE_LINE  = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // Pin level for a sync pulse given whether it is active and its polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern colour for one raster position.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned CW       = 4,
    parameter int unsigned CNT_W    = 11
) (
    input  logic [CNT_W-1:0] h,
    input  logic             chk_bit,   // h[CHK_LOG2] ^ v[CHK_LOG2]
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] line_col,
    input  logic [3*CW-1:0]  color_fg,
    output logic [3*CW-1:0]  color
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;

    // Bar index: number of bar boundaries already passed, saturating at bar 7.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h >= CNT_W'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    // Select the colour for the active pattern mode.
    always_comb begin
        color = '0;
        case (mode)
            MODE_LINE: begin
                if (h == line_col) color = color_fg;
            end
            MODE_BARS: begin
                color = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
            end
            MODE_CHECK: begin
                if (chk_bit) color = color_fg;
            end
            default: color = '0;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-shadowed test-pattern source.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CW       = 4,
    parameter int unsigned CNT_W    = 11,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] line_col,
    input  logic [3*CW-1:0]  color_fg,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [3*CW-1:0]  vga_o,
    output logic             frame_start,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             run_q, run_d;     // low after reset: next pix_ce restarts at (0,0)
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] line_col_q, line_col_d;
    logic [3*CW-1:0]  color_fg_q, color_fg_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [3*CW-1:0]  pix_q, pix_d;

    logic             wrap;
    logic             hs_act, vs_act, de_act, chk_bit;
    logic [3*CW-1:0]  pat_color;

    // Raster counters and frame-boundary capture of the pattern controls.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        run_d      = run_q;
        mode_d     = mode_q;
        line_col_d = line_col_q;
        color_fg_d = color_fg_q;
        wrap       = !run_q || ((h_q == H_LAST) && (v_q == V_LAST));
        if (pix_ce) begin
            run_d = 1'b1;
            if (wrap) begin
                h_d        = '0;
                v_d        = '0;
                mode_d     = mode;
                line_col_d = line_col;
                color_fg_d = color_fg;
            end else if (h_q == H_LAST) begin
                h_d = '0;
                v_d = v_q + ONE;
            end else begin
                h_d = h_q + ONE;
            end
        end
    end

    // Decode the next position so the registered outputs line up with hcnt/vcnt.
    always_comb begin
        hs_act  = (h_d >= HS_BEG) && (h_d < HS_END);
        vs_act  = (v_d >= VS_BEG) && (v_d < VS_END);
        de_act  = (h_d < H_ACT) && (v_d < V_ACT);
        chk_bit = h_d[CHK_LOG2] ^ v_d[CHK_LOG2];
    end

    vga_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .CW       (CW),
        .CNT_W    (CNT_W)
    ) u_pattern (
        .h        (h_d),
        .chk_bit  (chk_bit),
        .mode     (mode_d),
        .line_col (line_col_d),
        .color_fg (color_fg_d),
        .color    (pat_color)
    );

    // Output register next-state; everything holds on idle cycles except the frame strobe.
    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        de_d  = de_q;
        pix_d = pix_q;
        fs_d  = 1'b0;
        if (pix_ce) begin
            hs_d  = sync_level(hs_act, SYNC_POL);
            vs_d  = sync_level(vs_act, SYNC_POL);
            de_d  = de_act;
            pix_d = de_act ? pat_color : '0;
            fs_d  = wrap;
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q        <= '0;
            v_q        <= '0;
            run_q      <= 1'b0;
            mode_q     <= MODE_BLACK;
            line_col_q <= '0;
            color_fg_q <= '0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            de_q       <= 1'b0;
            pix_q      <= '0;
            fs_q       <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            run_q      <= run_d;
            mode_q     <= mode_d;
            line_col_q <= line_col_d;
            color_fg_q <= color_fg_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            pix_q      <= pix_d;
            fs_q       <= fs_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_o       = pix_q;
    assign frame_start = fs_q;
    assign hcnt        = h_q;
    assign vcnt        = v_q;

endmodule
